// File: rtl/baseline_pkg.sv
// baseline_pkg: shared FSM state type and derived width helpers for the accumulator
package baseline_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  function automatic int out_size_f(input int in0, input int in1, input int arr);
    return in0 + in1 + ($clog2(arr * ((in1 + 2) / 3)) - 1) * 2;
  endfunction
  function automatic int acc_size_f(input int in0, input int in1, input int arr, input int extra);
    return out_size_f(in0, in1, arr) + 1 + extra;
  endfunction
  function automatic int cnt_w_f(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction
endpackage

// File: rtl/baseline_acc_sat_add.sv
// sat_add: signed adder that clamps to the representable range and flags clamping
module sat_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_sat
);
  logic [W:0] w_full;
  assign w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};
  assign o_sat  = w_full[W] ^ w_full[W-1];
  // on overflow the true sign (bit W) picks the min or max rail
  assign o_sum  = o_sat ? {w_full[W], {(W-1){~w_full[W]}}} : w_full[W-1:0];
endmodule

// File: rtl/baseline_acc.sv
// baseline_acc: resolves redundant sum pairs and accumulates them with saturation,
// emitting one result per accumulation through a valid/ready handshake.
module baseline_acc
  import baseline_pkg::*;
#(
  parameter int IN_SIZE_0  = 4,
  parameter int IN_SIZE_1  = 8,
  parameter int ARRAY_SIZE = 8,
  parameter int ACC_EXTRA  = 8,
  parameter int MAX_BEATS  = 256,
  localparam int OUT_SIZE  = out_size_f(IN_SIZE_0, IN_SIZE_1, ARRAY_SIZE),
  localparam int ACC_SIZE  = acc_size_f(IN_SIZE_0, IN_SIZE_1, ARRAY_SIZE, ACC_EXTRA),
  localparam int CNT_W     = cnt_w_f(MAX_BEATS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [OUT_SIZE-1:0] in_0_i,
  input  logic [OUT_SIZE-1:0] in_1_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [ACC_SIZE-1:0] out_o,
  output logic                out_ovf_o,
  output logic [CNT_W-1:0]    out_beats_o
);
  state_t r_state, w_state_nxt;
  logic [ACC_SIZE-1:0] r_acc;
  logic                r_ovf;
  logic [CNT_W-1:0]    r_cnt;
  logic signed [OUT_SIZE:0]   w_s;
  logic signed [ACC_SIZE-1:0] w_s_ext;
  logic [ACC_SIZE-1:0] w_sum;
  logic                w_sat;
  logic                w_beat;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_last;

  assign w_s       = $signed({in_0_i[OUT_SIZE-1], in_0_i}) + $signed({in_1_i[OUT_SIZE-1], in_1_i});
  assign w_s_ext   = ACC_SIZE'(w_s);
  assign in_ready_o  = r_state != DONE;
  assign out_valid_o = r_state == DONE;
  assign w_beat    = in_valid_i && in_ready_o;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  // the beat that fills the counter closes the accumulation, so the count cannot wrap
  assign w_last    = in_last_i || (w_cnt_nxt == CNT_W'(MAX_BEATS));
  assign out_o       = r_acc;
  assign out_ovf_o   = r_ovf;
  assign out_beats_o = r_cnt;

  sat_add #(.W(ACC_SIZE)) u_sat_add (
    .i_a   (r_acc),
    .i_b   (w_s_ext),
    .o_sum (w_sum),
    .o_sat (w_sat)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == DONE) w_state_nxt = out_ready_i ? IDLE : DONE;
    else if (w_beat) w_state_nxt = w_last ? DONE : ACCUM;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == DONE) begin
      if (out_ready_i) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_cnt <= '0;
      end
    end else if (w_beat) begin
      r_acc <= (r_state == IDLE) ? w_s_ext : w_sum;
      r_ovf <= r_ovf | ((r_state == ACCUM) & w_sat);
      r_cnt <= w_cnt_nxt;
    end
  end
endmodule
